// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display users: active-low digit patterns,
// dark patterns for segments and anodes, and the digit-index type.
// Pure declarations, no logic.
package seg7_pkg;

  // Digit patterns {g,f,e,d,c,b,a}, active-low (0 lights the segment).
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // All four common-anode enables released (active-low).
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Digit position 0 (rightmost, seconds ones) .. 3 (leftmost, minutes tens).
  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// BCD nibble to active-low seven-segment pattern; non-BCD codes show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; anything above 9 is not a valid digit and shows a dash.
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit common-anode driver with frame snapshot, blanking,
// decimal-point mask and expiry flash. Outputs registered, 1-cycle latency.
// Optional: define LEAD_ZERO_BLANK_EN to blank digit 3 when it is zero. No backpressure.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000,
  parameter int BLINK_DIV   = 62
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        flash,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [15:0]   snap;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic          slot_tick;
  logic          frame_end;
  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic          off;
  logic          lead_zero;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign slot_tick = (presc == PRESC_LAST);
  assign frame_end = slot_tick && (idx == 2'd3);

  // Slot prescaler and digit index; the index only moves at slot boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (slot_tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Frame-rate state: latch a whole display value at once so a frame never
  // mixes old and new digits, and step the flash half-period counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap      <= 16'h0000;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      snap <= digits;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Pick the snapshot nibble for the digit currently being driven.
  always_comb begin
    cur_nib = snap[3:0];
    case (idx)
      2'd0: cur_nib = snap[3:0];
      2'd1: cur_nib = snap[7:4];
      2'd2: cur_nib = snap[11:8];
      2'd3: cur_nib = snap[15:12];
      default: cur_nib = snap[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

`ifdef LEAD_ZERO_BLANK_EN
  assign lead_zero = (idx == 2'd3) && (cur_nib == 4'd0);
`else
  assign lead_zero = 1'b0;
`endif

  // Next output values: dark whenever any off condition holds, otherwise one
  // anode low with its decoded pattern; dp_mask is deliberately used live.
  always_comb begin
    off     = blank | (flash & phase) | (presc < BLANK_LIM) | lead_zero;
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (!off) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = dec_seg;
      dp_nxt  = ~dp_mask[idx];
    end
  end

  // Output registers keep the pins glitch-free and start dark out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with REFRESH_DIV=8, BLANK_CYC=2, BLINK_DIV=2.
// Each slot is 2 dark cycles then 6 lit cycles; a frame is 32 cycles.
// Expected digit-3 zero behaviour follows LEAD_ZERO_BLANK_EN.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        flash;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [3:0] AN_D3Z  = 4'b1111;
  localparam logic [6:0] SEG_D3Z = 7'b1111111;
`else
  localparam logic [3:0] AN_D3Z  = 4'b0111;
  localparam logic [6:0] SEG_D3Z = 7'b1000000;
`endif

  seg7_scan #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2),
    .BLINK_DIV   (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .digits  (digits),
    .dp_mask (dp_mask),
    .flash   (flash),
    .blank   (blank),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] exp_v);
    n_cmp++;
    assert ({an, seg, dp} === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; also checks that never
  // more than one anode is low.
  task automatic step();
    @(posedge clk);
    #1;
    n_cmp++;
    assert ($countones(an) >= 3) else begin
      n_err++;
      $error("FAIL one_anode: observed an=%b, expected at most one low bit", an);
    end
  endtask

  // One slot: 2 blank cycles, then 6 cycles with the given lit values.
  task automatic run_slot(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    for (int c = 0; c < 8; c++) begin
      step();
      if (c < 2) chk({tag, "_blankint"}, {4'b1111, 7'b1111111, 1'b1});
      else       chk(tag, {e_an, e_seg, e_dp});
    end
  endtask

  // One frame with no pattern expectation; reports whether it was fully dark.
  task automatic run_frame_dark(output bit all_dark);
    all_dark = 1'b1;
    for (int c = 0; c < 32; c++) begin
      step();
      if (an !== 4'b1111) all_dark = 1'b0;
    end
  endtask

  initial begin
    bit d;
    int dark_frames;
    int lit_frames;

    reset   = 1'b1;
    digits  = 16'h1259;
    dp_mask = 4'b0000;
    flash   = 1'b0;
    blank   = 1'b0;

    // Reset held for 3 cycles: outputs dark.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset", {4'b1111, 7'b1111111, 1'b1});
    end
    reset = 1'b0;

    // Frame 0: snapshot still zero.
    run_slot("f0_s0", 4'b1110, 7'b1000000, 1'b1);
    run_slot("f0_s1", 4'b1101, 7'b1000000, 1'b1);
    run_slot("f0_s2", 4'b1011, 7'b1000000, 1'b1);
    run_slot("f0_s3", AN_D3Z,  SEG_D3Z,    1'b1);

    // Frame 1: 12:59; digits change during slot 1 must not show yet.
    run_slot("f1_s0_9", 4'b1110, 7'b0010000, 1'b1);
    digits = 16'h0830;
    run_slot("f1_s1_5", 4'b1101, 7'b0010010, 1'b1);
    run_slot("f1_s2_2", 4'b1011, 7'b0100100, 1'b1);
    run_slot("f1_s3_1", 4'b0111, 7'b1111001, 1'b1);

    // Frame 2: 08:30.
    digits = 16'h00AF;
    run_slot("f2_s0_0", 4'b1110, 7'b1000000, 1'b1);
    run_slot("f2_s1_3", 4'b1101, 7'b0110000, 1'b1);
    run_slot("f2_s2_8", 4'b1011, 7'b0000000, 1'b1);
    run_slot("f2_s3_0", AN_D3Z,  SEG_D3Z,    1'b1);

    // Frame 3: 00AF -> dashes, with decimal point on digit 2 only.
    dp_mask = 4'b0100;
    digits  = 16'h0045;
    run_slot("f3_s0_dash", 4'b1110, 7'b0111111, 1'b1);
    run_slot("f3_s1_dash", 4'b1101, 7'b0111111, 1'b1);
    run_slot("f3_s2_dp",   4'b1011, 7'b1000000, 1'b0);
    run_slot("f3_s3_0",    AN_D3Z,  SEG_D3Z,    1'b1);
    dp_mask = 4'b0000;

    // Frame 4: 00:45, leading digit behaviour.
    run_slot("f4_s0_5",  4'b1110, 7'b0010010, 1'b1);
    run_slot("f4_s1_4",  4'b1101, 7'b0011001, 1'b1);
    run_slot("f4_s2_0",  4'b1011, 7'b1000000, 1'b1);
    run_slot("f4_s3_lz", AN_D3Z,  SEG_D3Z,    1'b1);

    // Flash: over 4 frames exactly 2 are fully dark and 2 are lit.
    flash = 1'b1;
    dark_frames = 0;
    lit_frames  = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame_dark(d);
      if (d) dark_frames++;
      else   lit_frames++;
    end
    n_cmp++;
    assert (dark_frames === 2) else begin
      n_err++;
      $error("FAIL flash_dark_frames: observed %0d, expected 2", dark_frames);
    end
    n_cmp++;
    assert (lit_frames === 2) else begin
      n_err++;
      $error("FAIL flash_lit_frames: observed %0d, expected 2", lit_frames);
    end

    // blank together with flash: dark for two whole frames.
    blank = 1'b1;
    for (int c = 0; c < 64; c++) begin
      step();
      chk("blank_flash", {4'b1111, 7'b1111111, 1'b1});
    end
    blank = 1'b0;
    flash = 1'b0;

    // Reset pulse mid-slot (slot 1, prescaler 3).
    for (int c = 0; c < 11; c++) step();
    chk("pre_reset_lit", {4'b1101, 7'b0011001, 1'b1});
    reset = 1'b1;
    step();
    chk("mid_reset", {4'b1111, 7'b1111111, 1'b1});
    reset = 1'b0;
    // Index restarts at 0 and the snapshot is cleared to zero.
    run_slot("post_reset_s0", 4'b1110, 7'b1000000, 1'b1);
    run_slot("post_reset_s1", 4'b1101, 7'b1000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
